piso_shift_tx: RTL and testbench
================================

Name: piso_shift_tx

Overview:
Parallel-in serial-out shift transmitter. It is the sending end for the team's serial-in parallel-out shift registers. A WIDTH-bit word is accepted through a valid/ready load handshake, then driven out on dout one bit per enabled clock. A one-cycle done pulse marks the end of each frame. It feeds a SIPO receiver clocked by the same clk, where din = dout and the receiver shifts only while dout_valid = 1.

Parameters:
WIDTH, 4, number of bits per frame (legal range 2..32)
MSB_FIRST, 1, 1 = transmit pdata[WIDTH-1] first; 0 = transmit pdata[0] first

Ports:
clk  input  1  system clock; all state changes on the rising edge
rst  input  1  reset, asynchronous, active-high
load_valid  input  1  pdata is offered for transmission
load_ready  output  1  block can accept a word (high only in IDLE)
pdata  input  WIDTH  parallel word, sampled only on an accepted load
shift_en  input  1  advance one bit this cycle (stall when low)
dout  output  1  current serial bit
dout_valid  output  1  dout carries a frame bit
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the last bit of a frame

Behaviour:
- Reset (async assert, any state): state = IDLE, shreg = 0, cnt = 0, dout = 0, dout_valid = 0, busy = 0, done = 0, load_ready = 1.
- Reset takes effect immediately, with no clock edge. Asserting rst mid-frame aborts the frame: no done pulse, and the remaining bits are discarded.
- State machine has two states, IDLE and SHIFT.
- IDLE:
  - load_ready = 1.
  - On an edge with load_valid = 1: shreg <= pdata, cnt <= 0, state <= SHIFT.
  - Load is accepted regardless of shift_en.
- SHIFT:
  - busy = 1, dout_valid = 1, load_ready = 0.
  - dout = shreg[WIDTH-1] when MSB_FIRST = 1, otherwise shreg[0]. dout is taken directly from the register, with no combinational path from inputs.
  - Edge with shift_en = 1 and cnt < WIDTH-1: shift toward the output end, fill with 0, cnt <= cnt + 1.
  - Edge with shift_en = 1 and cnt = WIDTH-1: state <= IDLE, done <= 1 for exactly the following cycle, shreg <= 0.
  - Edge with shift_en = 0: shreg, cnt and dout all hold; dout_valid stays 1.
- Latency:
  - The first bit appears on dout in the cycle after the accepting edge.
  - With shift_en held high, a frame occupies exactly WIDTH cycles of dout_valid.
  - done is high in the cycle immediately after the last valid bit.
- Loads are ignored while busy. load_valid and pdata are don't-care in SHIFT; a word offered then is neither captured nor queued.
- The done cycle is an IDLE cycle, so load_ready = 1 alongside done. A load accepted there starts the next frame. The minimum inter-frame gap is therefore 1 cycle with dout_valid = 0.
- In IDLE, dout = 0 and dout_valid = 0.
- cnt width is clog2(WIDTH); there is no wrap within a frame.
- shift_en is ignored in IDLE.

Test Plan:
1. Assert rst with no clock running -> dout = 0, dout_valid = 0, busy = 0, done = 0, load_ready = 1. Release rst; state is unchanged until a load.
2. Defaults; load pdata = 4'b1011, shift_en = 1 -> dout = 1,0,1,1 on the next 4 cycles with dout_valid = 1. The 5th cycle has done = 1, dout_valid = 0, load_ready = 1. A SIPO fed from dout/dout_valid then holds 4'b1011.
3. Load 4'b1100; drop shift_en for 2 cycles after the first bit -> dout = 1,1,1,1,0,0 over 6 cycles with dout_valid = 1 throughout. done follows the 6th cycle.
4. Load 4'b1011; during the frame drive load_valid = 1, pdata = 4'b0110 -> the transmitted sequence is still 1,0,1,1 and load_ready = 0 for those 4 cycles. 0110 is then accepted in the done cycle: dout = 0,1,1,0 starts on the next cycle.
5. Load 4'b1111; assert rst after 2 bits -> dout = 0, dout_valid = 0, busy = 0 immediately, and no done pulse. Release, load 4'b0001 -> 0,0,0,1.
6. MSB_FIRST = 0, WIDTH = 8, load 8'hA5 -> dout = 1,0,1,0,0,1,0,1, with done after the 8th bit.

Source files
------------

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// load, then shifts it out one bit per enabled clock and pulses done afterwards.
module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pdata,
    input  logic             shift_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shreg_reg, shreg_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               done_reg, done_next;
    logic [WIDTH-1:0]   shreg_shifted;
    logic               out_bit;

    // Output end and shift direction depend on bit order; vacated bits fill with 0.
    generate
        if (MSB_FIRST) begin : g_msb
            assign out_bit       = shreg_reg[WIDTH-1];
            assign shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign out_bit       = shreg_reg[0];
            assign shreg_shifted = {1'b0, shreg_reg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (load_valid) begin
                    shreg_next = pdata;
                    cnt_next   = '0;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt_reg == LAST_CNT) begin
                        state_next = IDLE;
                        shreg_next = '0;
                        done_next  = 1'b1;
                    end else begin
                        shreg_next = shreg_shifted;
                        cnt_next   = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // All outputs decode registered state only, so dout has no input-to-output path.
    assign busy       = (state_reg == SHIFT);
    assign dout_valid = busy;
    assign load_ready = (state_reg == IDLE);
    assign dout       = busy & out_bit;
    assign done       = done_reg;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: a 4-bit MSB-first and an 8-bit LSB-first instance
// checked every cycle against a queue-of-pending-bits reference model.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       clk_run = 1'b0;
    logic       rst = 1'b0;
    logic       lv = 1'b0;
    logic       se = 1'b0;
    logic [3:0] pd4 = '0;
    logic [7:0] pd8 = '0;

    logic ready4, dout4, dv4, busy4, done4;
    logic ready8, dout8, dv8, busy8, done8;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: bits still to be sent, in wire order, plus pending done.
    bit         q4[$];
    bit         q8[$];
    bit         mdone4 = 1'b0;
    bit         mdone8 = 1'b0;
    logic [3:0] word4 = '0, sipo4 = '0;
    logic [7:0] word8 = '0, sipo8 = '0;

    always #5 clk = clk_run ? ~clk : 1'b0;

    piso_shift_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut4 (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready4), .pdata(pd4),
        .shift_en(se), .dout(dout4), .dout_valid(dv4), .busy(busy4), .done(done4)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst), .load_valid(lv), .load_ready(ready8), .pdata(pd8),
        .shift_en(se), .dout(dout8), .dout_valid(dv8), .busy(busy8), .done(done8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Packed as {load_ready, dout, dout_valid, busy, done}.
    task automatic compare_all();
        logic [4:0] e4, e8;
        e4 = {q4.size() == 0, (q4.size() != 0) ? q4[0] : 1'b0,
              q4.size() != 0, q4.size() != 0, mdone4};
        e8 = {q8.size() == 0, (q8.size() != 0) ? q8[0] : 1'b0,
              q8.size() != 0, q8.size() != 0, mdone8};
        check("outs4", {27'd0, ready4, dout4, dv4, busy4, done4}, {27'd0, e4});
        check("outs8", {27'd0, ready8, dout8, dv8, busy8, done8}, {27'd0, e8});
        if (mdone4) check("sipo4", {28'd0, sipo4}, {28'd0, word4});
        if (mdone8) check("sipo8", {24'd0, sipo8}, {24'd0, word8});
    endtask

    task automatic model_edge();
        if (q4.size() == 0) begin
            mdone4 = 1'b0;
            if (lv) begin
                for (int i = 3; i >= 0; i--) q4.push_back(pd4[i]);
                word4 = pd4;
                $display("load4 word=%h", pd4);
            end
        end else begin
            mdone4 = 1'b0;
            if (se) begin
                void'(q4.pop_front());
                if (q4.size() == 0) mdone4 = 1'b1;
            end
        end
        if (q8.size() == 0) begin
            mdone8 = 1'b0;
            if (lv) begin
                for (int i = 0; i < 8; i++) q8.push_back(pd8[i]);
                word8 = pd8;
                $display("load8 word=%h", pd8);
            end
        end else begin
            mdone8 = 1'b0;
            if (se) begin
                void'(q8.pop_front());
                if (q8.size() == 0) mdone8 = 1'b1;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, clock once, check after the next falling edge.
    task automatic cycle(input logic l, input logic [3:0] p4, input logic [7:0] p8, input logic s);
        lv  = l;
        pd4 = p4;
        pd8 = p8;
        se  = s;
        // Receiving SIPOs see the DUT wire and shift only on valid, enabled cycles.
        if (dv4 && se) sipo4 = {sipo4[2:0], dout4};
        if (dv8 && se) sipo8 = {dout8, sipo8[7:1]};
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q4.delete();
        q8.delete();
        mdone4 = 1'b0;
        mdone8 = 1'b0;
        $display("reset asserted");
        compare_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
    endtask

    initial begin
        // Reset with no clock running must act immediately.
        #3 rst = 1'b1;
        #2 compare_all();
        clk_run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare_all();
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'hF, 8'hFF, i[0]);

        // Plain MSB-first frame.
        cycle(1'b1, 4'b1011, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 8'h00, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 8'h00, 1'b1);

        // Stall for two cycles after the first bit.
        cycle(1'b1, 4'b1100, 8'h00, 1'b1);
        cycle(1'b0, 4'h0, 8'h00, 1'b0);
        cycle(1'b0, 4'h0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 8'h00, 1'b1);

        // Load offered during a frame is ignored, then taken in the done cycle.
        cycle(1'b1, 4'b1011, 8'h3C, 1'b1);
        for (int i = 0; i < 9; i++) cycle(1'b1, 4'b0110, 8'h3C, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 8'h00, 1'b1);

        // Reset mid-frame aborts without a done pulse.
        cycle(1'b1, 4'b1111, 8'hFF, 1'b1);
        cycle(1'b0, 4'h0, 8'h00, 1'b1);
        do_reset();
        cycle(1'b0, 4'h0, 8'h00, 1'b1);
        cycle(1'b1, 4'b0001, 8'h01, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 8'h00, 1'b1);

        // LSB-first 8-bit frame.
        cycle(1'b1, 4'h9, 8'hA5, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 8'h00, 1'b1);

        // Randomized traffic with stalls, busy-time offers and occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else cycle($urandom_range(0, 2) == 0, 4'($urandom), 8'($urandom),
                       $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
